// File: rtl/serial_word_feeder.sv
// Serializes parallel words onto a 1-bit stream, with an optional even-parity bit at the end of each frame.
// Latency: the first frame bit appears on out_bit one cycle after the accept edge; a frame lasts WIDTH+APPEND_PARITY cycles.
// Backpressure: in_ready is high only in IDLE or on the last bit of a frame, so back-to-back words stream with no gap.
module serial_word_feeder #(
    parameter int WIDTH         = 8,
    parameter bit LSB_FIRST     = 1'b1,
    parameter bit APPEND_PARITY = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_active,
    output logic             frame_end
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [CW-1:0]    cnt, cnt_n, cnt_inc;
    logic             par, par_n;
    logic             bit_n, act_n, end_n;
    logic             accept;

    // Bit that leaves the word first in the chosen shift direction.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    // Word with its head bit removed; the vacated end fills with zero.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
    endfunction

    // frame_end marks the last bit being presented, which is exactly when a new word may start.
    assign in_ready = rst & ((state == IDLE) | frame_end);
    assign accept   = in_valid & in_ready;
    assign cnt_inc  = cnt + CW'(1);

    // Next-state and next-output selection; outputs default to the idle pattern.
    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        par_n   = par;
        bit_n   = 1'b0;
        act_n   = 1'b0;
        end_n   = 1'b0;
        if (accept) begin
            // The head bit goes straight into the output register; sh keeps the rest.
            bit_n   = head(in_data);
            sh_n    = advance(in_data);
            cnt_n   = '0;
            par_n   = head(in_data);
            act_n   = 1'b1;
            state_n = DATA;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = IDLE;
                end
                DATA: begin
                    if (cnt != LAST) begin
                        bit_n = head(sh);
                        sh_n  = advance(sh);
                        par_n = par ^ head(sh);
                        cnt_n = cnt_inc;
                        act_n = 1'b1;
                        end_n = (cnt_inc == LAST) && !APPEND_PARITY;
                    end else if (APPEND_PARITY) begin
                        // par already covers all WIDTH data bits here.
                        bit_n   = par;
                        act_n   = 1'b1;
                        end_n   = 1'b1;
                        state_n = PAR;
                    end else begin
                        state_n = IDLE;
                        sh_n    = '0;
                        cnt_n   = '0;
                        par_n   = 1'b0;
                    end
                end
                PAR: begin
                    state_n = IDLE;
                    sh_n    = '0;
                    cnt_n   = '0;
                    par_n   = 1'b0;
                end
                default: begin
                    state_n = IDLE;
                    sh_n    = '0;
                    cnt_n   = '0;
                    par_n   = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sh         <= '0;
            cnt        <= '0;
            par        <= 1'b0;
            out_bit    <= 1'b0;
            out_active <= 1'b0;
            frame_end  <= 1'b0;
        end else begin
            state      <= state_n;
            sh         <= sh_n;
            cnt        <= cnt_n;
            par        <= par_n;
            out_bit    <= bit_n;
            out_active <= act_n;
            frame_end  <= end_n;
        end
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Randomized and directed bench for serial_word_feeder in two configurations (LSB-first with parity, MSB-first without).
// Each cycle the outputs are compared against a queue of the frame bits still owed, built from each accepted word.
// Stimulus holds and drops in_valid freely and changes in_data every cycle; reset is asserted at random points.
module tb_serial_word_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [7:0] a_data  = '0;
    logic       a_valid = 1'b0;
    logic       a_ready, a_bit, a_active, a_end;
    logic [7:0] b_data  = '0;
    logic       b_valid = 1'b0;
    logic       b_ready, b_bit, b_active, b_end;

    serial_word_feeder #(.WIDTH(8), .LSB_FIRST(1'b1), .APPEND_PARITY(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .out_bit(a_bit), .out_active(a_active), .frame_end(a_end)
    );

    serial_word_feeder #(.WIDTH(8), .LSB_FIRST(1'b0), .APPEND_PARITY(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .out_bit(b_bit), .out_active(b_active), .frame_end(b_end)
    );

    always #5 clk = ~clk;

    // Frame bits still owed by each DUT; the front entry is the bit on out_bit now.
    logic qa[$];
    logic qb[$];
    logic acc_a, acc_b;
    logic xa = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // One clock cycle: drive inputs, check outputs, then advance the model across the edge.
    task automatic tick(input logic r, input logic va, input logic [7:0] da,
                        input logic vb, input logic [7:0] db);
        rst = r; a_valid = va; a_data = da; b_valid = vb; b_data = db;
        #1;
        chk("a_bit",    {31'd0, a_bit},    {31'd0, (qa.size() > 0) ? qa[0] : 1'b0});
        chk("a_active", {31'd0, a_active}, {31'd0, qa.size() > 0});
        chk("a_end",    {31'd0, a_end},    {31'd0, qa.size() == 1});
        chk("a_ready",  {31'd0, a_ready},  {31'd0, r && qa.size() <= 1});
        chk("b_bit",    {31'd0, b_bit},    {31'd0, (qb.size() > 0) ? qb[0] : 1'b0});
        chk("b_active", {31'd0, b_active}, {31'd0, qb.size() > 0});
        chk("b_end",    {31'd0, b_end},    {31'd0, qb.size() == 1});
        chk("b_ready",  {31'd0, b_ready},  {31'd0, r && qb.size() <= 1});
        if (a_active) xa = xa ^ a_bit;
        acc_a = va && r && (qa.size() <= 1);
        acc_b = vb && r && (qb.size() <= 1);
        @(posedge clk);
        if (!r) begin
            qa.delete();
            qb.delete();
        end else begin
            if (qa.size() > 0) void'(qa.pop_front());
            if (qb.size() > 0) void'(qb.pop_front());
            if (acc_a) begin
                for (int i = 0; i < 8; i++) qa.push_back(da[i]);
                qa.push_back(^da);
            end
            if (acc_b) begin
                for (int i = 7; i >= 0; i--) qb.push_back(db[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic send_a(input logic [7:0] w);
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b1, w, 1'b0, 8'h00);
            if (acc_a) break;
        end
        chk("a_accept", {31'd0, acc_a}, 32'd1);
    endtask

    task automatic send_b(input logic [7:0] w);
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0, 8'h00, 1'b1, w);
            if (acc_b) break;
        end
        chk("b_accept", {31'd0, acc_b}, 32'd1);
    endtask

    initial begin
        @(negedge clk);
        // Reset with valid asserted: reset must win.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'hA5, 1'b1, 8'h5A);
        idle(10);

        // 0xB4 LSB-first with parity; the downstream XOR state returns to its start value.
        xa = 1'b0;
        send_a(8'hB4);
        idle(11);
        chk("xor_after_frame", {31'd0, xa}, 32'd0);

        // Back-to-back 0x01 then 0x03 with valid held high.
        send_a(8'h01);
        send_a(8'h03);
        idle(20);

        // MSB-first without parity.
        send_b(8'h81);
        idle(10);

        // Reset during the 4th bit of 0xFF, then a clean 0x00 frame.
        send_a(8'hFF);
        idle(3);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        send_a(8'h00);
        idle(11);

        // Random traffic: data changes every cycle, valid drops at random, occasional reset.
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 3) != 0), 8'($urandom()),
                 ($urandom_range(0, 3) != 0), 8'($urandom()));
        end
        idle(12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_word_feeder.md
# serial_word_feeder

Upstream feeder for the single-bit running-XOR state stage. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a 1-bit stream. It can optionally append an even-parity bit to each frame. When there is no word to send it drives 0, so the downstream XOR state holds its value between frames.

## Interface
Parameters:
- WIDTH, 8, data bits per word; legal range 2..32.
- LSB_FIRST, 1, 1 = bit 0 shifted first; 0 = bit WIDTH-1 first.
- APPEND_PARITY, 1, 1 = emit one extra bit per frame equal to the XOR of the word's bits; 0 = data bits only.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low. While rst=0 at a clk edge, all state returns to reset values.
- in_data  input  WIDTH  word to serialize; sampled only on an accepted transfer.
- in_valid  input  1  word present on in_data.
- in_ready  output  1  feeder can take a word this cycle. Transfer occurs when in_valid & in_ready at a rising edge.
- out_bit  output  1  serial stream to the downstream stage; registered.
- out_active  output  1  out_bit carries a frame bit this cycle; registered.
- frame_end  output  1  out_bit is the last bit of the current frame; registered.

## Operation
- There are three states: IDLE, DATA and PAR. PAR is unused when APPEND_PARITY=0.
- Internal registers:
  - shift register sh[WIDTH-1:0]
  - bit counter cnt, width clog2(WIDTH), counts 0..WIDTH-1
  - parity accumulator par
- IDLE:
  - out_bit=0, out_active=0, frame_end=0.
  - On accept: load sh=in_data, set cnt=0, go to DATA.
  - The registered out_bit becomes the first bit on the next cycle. With LSB_FIRST, that is in_data[0].
- DATA:
  - Each cycle presents one bit: sh[0] when LSB_FIRST, sh[WIDTH-1] otherwise.
  - sh shifts by one toward the output end; vacated bits fill with 0.
  - par ^= presented bit; cnt increments.
  - When the presented bit is at cnt==WIDTH-1:
    - If APPEND_PARITY=1: go to PAR.
    - Else the frame ends this cycle; see back-to-back below.
- PAR: presents out_bit = par, which is the XOR of all WIDTH data bits. This is the frame's last bit.
- Frame bit counts:
  - APPEND_PARITY=1: WIDTH+1 bits per frame. The XOR of all frame bits is 0, so the downstream XOR state is unchanged after each complete frame.
  - APPEND_PARITY=0: WIDTH bits per frame.
- in_ready (combinational): rst & (state==IDLE | last bit of frame currently presented).
- Back-to-back:
  - When a transfer is accepted on the last-bit cycle, the next cycle presents bit 0 of the new word.
  - No idle bubble occurs; out_active stays 1.
  - par clears to 0 for the new frame.
- No accept on the last-bit cycle: return to IDLE; out_bit drops to 0 on the next cycle.
- in_data is ignored whenever no transfer occurs. in_valid may drop without penalty; there is no obligation to hold.

## Timing
- Reset values: state=IDLE, sh=0, cnt=0, par=0, out_bit=0, out_active=0, frame_end=0.
- in_ready=0 while rst=0; it becomes 1 in the first cycle after reset is released.
- Latency from accept edge to first frame bit on out_bit is 1 cycle.
- Frame occupies exactly WIDTH+APPEND_PARITY consecutive cycles of out_active=1.
- frame_end is 1 for exactly one cycle per frame, coincident with the last bit.
- Sustained throughput is one word per WIDTH+APPEND_PARITY cycles with in_valid held high.
- Reset mid-frame: on the edge where rst=0, the frame is abandoned and all registers take reset values. No partial parity bit is emitted, and the next cycle shows out_bit=0, out_active=0.
- Reset and in_valid in the same cycle: reset wins and no transfer occurs, since in_ready=0.

## Test plan
- Reset, then idle 10 cycles with in_valid=0 → out_bit=0, out_active=0, frame_end=0 every cycle; in_ready=1 from the first post-reset cycle.
- WIDTH=8, LSB_FIRST=1, APPEND_PARITY=1; send 0xB4 → out_bit = 0,0,1,0,1,1,0,1 then parity 0. frame_end is high on the 9th bit only. The downstream XOR state equals its pre-frame value afterwards.
- Same configuration; send 0x01 then 0x03 with in_valid held high → 18 contiguous active cycles with no gap. Parity bits are 1 and 0. in_ready is high only on cycles 9 and 18.
- LSB_FIRST=0, APPEND_PARITY=0; send 0x81 → bits 1,0,0,0,0,0,0,1. in_ready is high on the 8th bit, and out_active falls the cycle after.
- Send 0xFF, assert rst=0 during the 4th bit → the next cycle has out_bit=0, out_active=0, in_ready=0. After release, send 0x00 → 8 zeros, parity 0, with no leftover bits from 0xFF.
- Hold in_valid=1 with in_data changing every cycle mid-frame → only the words sampled on accept edges appear on out_bit.
